// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU, cache-array and memory signal bundle for cache_ctrl
interface cache_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUMBER_OF_SETS = 1
);
  logic cpu_req;
  logic cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic cpu_ready;
  logic cpu_done;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic c_cs;
  logic c_we;
  logic c_re;
  logic c_rpe;
  logic [NUMBER_OF_SETS-1:0] c_set_sel;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic c_wdata_oe;
  logic [DATA_WIDTH-1:0] c_rdata;
  logic c_hit;
  logic mem_req;
  logic mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic mem_ack;
  modport master (
    input cpu_req, cpu_we, cpu_addr, cpu_wdata, c_rdata, c_hit, mem_rdata, mem_ack,
    output cpu_ready, cpu_done, cpu_rdata, c_addr, c_cs, c_we, c_re, c_rpe, c_set_sel,
    output c_wdata, c_wdata_oe, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, c_rdata, c_hit, mem_rdata, mem_ack,
    input cpu_ready, cpu_done, cpu_rdata, c_addr, c_cs, c_we, c_re, c_rpe, c_set_sel,
    input c_wdata, c_wdata_oe, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: lookup/refill/write-through sequencer; store-miss allocate when CACHE_CTRL_WRITE_ALLOCATE_EN is defined
module cache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUMBER_OF_SETS = 1
) (
  input logic clk,
  input logic rst,
  cache_ctrl_if.master bus
);
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
  localparam bit WA = 1'b1;
`else
  localparam bit WA = 1'b0;
`endif
  localparam int VW = NUMBER_OF_SETS > 1 ? $clog2(NUMBER_OF_SETS) : 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, REFILL, DONE} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, miss_q, miss_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, refill_q, refill_d, rdata_q, rdata_d;
  logic [VW-1:0] victim_q, victim_d;
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    miss_d = miss_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    refill_d = refill_q;
    rdata_d = rdata_q;
    victim_d = victim_q;
    case (state_q)
      IDLE: if (bus.cpu_req) begin
        we_d = bus.cpu_we;
        addr_d = bus.cpu_addr;
        wdata_d = bus.cpu_wdata;
        state_d = LOOKUP;
      end
      LOOKUP: if (we_q) begin
        miss_d = !bus.c_hit;
        state_d = MEM_WR;
      end else if (bus.c_hit) begin
        rdata_d = bus.c_rdata;
        state_d = DONE;
      end else begin
        state_d = MEM_RD;
      end
      MEM_RD: if (bus.mem_ack) begin
        refill_d = bus.mem_rdata;
        rdata_d = bus.mem_rdata;
        state_d = REFILL;
      end
      MEM_WR: if (bus.mem_ack) begin
        refill_d = wdata_q;
        state_d = (WA && miss_q) ? REFILL : DONE;
      end
      REFILL: begin
        victim_d = victim_q == VW'(NUMBER_OF_SETS - 1) ? '0 : victim_q + 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      miss_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      refill_q <= '0;
      rdata_q <= '0;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      miss_q <= miss_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      refill_q <= refill_d;
      rdata_q <= rdata_d;
      victim_q <= victim_d;
    end
  end
  assign bus.cpu_ready = state_q == IDLE;
  assign bus.cpu_done = state_q == DONE;
  assign bus.cpu_rdata = rdata_q;
  assign bus.c_addr = addr_q;
  assign bus.c_cs = state_q == LOOKUP || state_q == REFILL;
  assign bus.c_we = state_q == LOOKUP && we_q;
  assign bus.c_re = state_q == LOOKUP && !we_q;
  assign bus.c_rpe = state_q == REFILL;
  assign bus.c_set_sel = state_q == LOOKUP ? '1 :
                         state_q == REFILL ? NUMBER_OF_SETS'(1) << victim_q : '0;
  assign bus.c_wdata_oe = bus.c_we || bus.c_rpe;
  assign bus.c_wdata = bus.c_we ? wdata_q : bus.c_rpe ? refill_q : '0;
  assign bus.mem_req = state_q == MEM_RD || state_q == MEM_WR;
  assign bus.mem_we = state_q == MEM_WR;
  assign bus.mem_addr = bus.mem_req ? addr_q : '0;
  assign bus.mem_wdata = bus.mem_we ? wdata_q : '0;
endmodule
